// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier driving an external ALU_cell chain.
// Latency 2*WIDTH+1 cycles from accepted start to done; start is ignored unless IDLE (no other backpressure).
// Optional ALU_MUL_ZERO_BYPASS_EN: zero operands finish in one cycle with prod=0.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod,
  output logic [WIDTH-1:0]     alu_A,
  output logic [WIDTH-1:0]     alu_B,
  output logic [1:0]           alu_mode,
  input  logic [WIDTH-1:0]     alu_Y,
  input  logic                 alu_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mcand, acc, mplr;
  logic [CW-1:0]     cnt, cnt_inc;
  logic              carry;
  logic              last_shift;
  logic [2*WIDTH:0]  sh;

  // One logical right shift of the {carry, acc, mplr} chain; carry refills with 0.
  assign sh         = {carry, acc, mplr} >> 1;
  assign cnt_inc    = cnt + 1'b1;
  assign last_shift = (cnt_inc == CW'(WIDTH));

`ifdef ALU_MUL_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (a == '0) || (b == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_A     = '0;
    alu_B     = '0;
    alu_mode  = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ALU_MUL_ZERO_BYPASS_EN
          state_nxt = zero_op ? DONE : ADD;
`else
          state_nxt = ADD;
`endif
        end
      end
      ADD: begin
        busy      = 1'b1;
        alu_A     = acc;
        alu_B     = mplr[0] ? mcand : '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = last_shift ? DONE : ADD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mplr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= '0;
            mplr  <= b;
            cnt   <= '0;
            carry <= 1'b0;
`ifdef ALU_MUL_ZERO_BYPASS_EN
            if (zero_op) prod <= '0;
`endif
          end
        end
        // The add is issued every iteration so latency never depends on operand bits.
        ADD: begin
          acc   <= alu_Y;
          carry <= alu_cout;
        end
        SHIFT: begin
          carry <= sh[2*WIDTH];
          acc   <= sh[2*WIDTH-1:WIDTH];
          mplr  <= sh[WIDTH-1:0];
          cnt   <= cnt_inc;
          if (last_shift) prod <= sh[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
